// File: rtl/shift_packer.sv
// shift_packer: packs IN_W-bit lanes into RATIO-lane words with flush and back-pressure
module shift_packer #(
  parameter int IN_W = 8,
  parameter int RATIO = 4,
  parameter int MSB_FIRST = 1,
  localparam int OUT_W = IN_W * RATIO,
  localparam int CW = $clog2(RATIO),
  localparam int OCW = $clog2(RATIO + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OCW-1:0]   out_count,
  output logic             flush_pend
);
  logic [OUT_W-1:0] acc, acc_next;
  logic [CW-1:0] cnt, lane;
  logic out_free, last, acc_in, full, fl_exec, fl_done;
  // handshake decode and lane insertion into the accumulator
  always_comb begin
    out_free = !out_valid || out_ready;
    last = cnt == CW'(RATIO - 1);
    in_ready = rst_n && !flush_pend && (!last || out_free);
    acc_in = in_valid && in_ready;
    full = acc_in && last;
    fl_exec = flush_pend && out_free && cnt != '0;
    fl_done = flush_pend && (out_free || cnt == '0);
    lane = MSB_FIRST != 0 ? CW'(RATIO - 1) - cnt : cnt;
    acc_next = acc;
    for (int i = 0; i < RATIO; i++)
      if (acc_in && lane == CW'(i)) acc_next[i*IN_W +: IN_W] = in_data;
  end
  // output register, accumulator, lane counter and latched flush
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data <= '0;
      out_count <= '0;
      out_valid <= 1'b0;
      acc <= '0;
      cnt <= '0;
      flush_pend <= 1'b0;
    end else begin
      if (full) begin
        out_data <= acc_next;
        out_count <= OCW'(RATIO);
        out_valid <= 1'b1;
      end else if (fl_exec) begin
        out_data <= acc;
        out_count <= OCW'(cnt);
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      acc <= (full || fl_exec) ? '0 : acc_next;
      cnt <= (full || fl_exec) ? '0 : cnt + CW'(acc_in);
      flush_pend <= flush || (flush_pend && !fl_done);
    end
  end
endmodule

// File: tb/tb_shift_packer.sv
// tb_shift_packer: lane-queue reference model checks for both lane orders
module tb_shift_packer;
  logic clk = 1'b0;
  logic rst_n, in_valid, flush, out_ready;
  logic [7:0] in_data;
  logic [31:0] od_m, od_l;
  logic ov_m, ov_l, ir_m, ir_l, fp_m, fp_l;
  logic [2:0] oc_m, oc_l;
  int total = 0;
  int bad = 0;
  bit [7:0] pend[$];
  bit mv = 0;
  bit fp = 0;
  bit clean = 1;
  bit [31:0] mdm = 0;
  bit [31:0] mdl = 0;
  bit [2:0] mc = 0;
  bit last_acc;

  always #5 clk = ~clk;

  shift_packer #(.IN_W(8), .RATIO(4), .MSB_FIRST(1)) u_m (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(ir_m),
    .flush(flush), .out_data(od_m), .out_valid(ov_m), .out_ready(out_ready),
    .out_count(oc_m), .flush_pend(fp_m));

  shift_packer #(.IN_W(8), .RATIO(4), .MSB_FIRST(0)) u_l (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(ir_l),
    .flush(flush), .out_data(od_l), .out_valid(ov_l), .out_ready(out_ready),
    .out_count(oc_l), .flush_pend(fp_l));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit [31:0] pack(input bit msb);
    bit [31:0] w = 0;
    foreach (pend[i]) begin
      if (msb) w[(3-i)*8 +: 8] = pend[i];
      else w[i*8 +: 8] = pend[i];
    end
    return w;
  endfunction

  task automatic cyc(input bit r, input bit iv, input bit [7:0] d, input bit fl, input bit ordy, input bit chk_en);
    bit exp_ir, free, acc, nfp;
    int len;
    rst_n = r; in_valid = iv; in_data = d; flush = fl; out_ready = ordy;
    #1;
    free = !mv || ordy;
    len = pend.size();
    exp_ir = r && !fp && (len < 3 || free);
    if (chk_en) begin
      chk("in_ready_m", ir_m, exp_ir);
      chk("in_ready_l", ir_l, exp_ir);
      chk("out_valid_m", ov_m, mv);
      chk("out_valid_l", ov_l, mv);
      chk("flush_pend", fp_m, fp);
      if (mv || clean) begin
        chk("out_data_m", od_m, mdm);
        chk("out_data_l", od_l, mdl);
        chk("out_count", oc_m, mc);
        chk("out_count_l", oc_l, mc);
      end
    end
    acc = iv && exp_ir;
    last_acc = acc;
    if (!r) begin
      pend.delete(); mv = 0; fp = 0; mdm = 0; mdl = 0; mc = 0; clean = 1;
    end else begin
      nfp = fl || (fp && !(len == 0 || free));
      if (acc) pend.push_back(d);
      if (acc && pend.size() == 4) begin
        mdm = pack(1); mdl = pack(0); mc = 4; mv = 1; clean = 0; pend.delete();
      end else if (fp && free && len > 0) begin
        mdm = pack(1); mdl = pack(0); mc = 3'(len); mv = 1; clean = 0; pend.delete();
      end else if (ordy) mv = 0;
      fp = nfp;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int k;
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 2; i++) cyc(1, 0, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) cyc(1, 1, 8'(8'h11 * (i + 1)), 0, 1, 1);
    chk("word_msb", od_m, 32'h11223344);
    chk("word_lsb", od_l, 32'h44332211);
    for (int i = 0; i < 2; i++) cyc(1, 0, 0, 0, 1, 1);
    for (int i = 0; i < 16; i++) cyc(1, 1, 8'(i), 0, 1, 1);
    for (int i = 0; i < 2; i++) cyc(1, 0, 0, 0, 1, 1);
    k = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1, k < 8, 8'(8'hA0 + k), 0, 0, 1);
      if (last_acc) k++;
    end
    chk("bp_stalled", k, 7);
    for (int i = 0; i < 20 && k < 8; i++) begin
      cyc(1, 1, 8'(8'hA0 + k), 0, 1, 1);
      if (last_acc) k++;
    end
    chk("bp_all", k, 8);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 1, 1);
    cyc(1, 1, 8'hDE, 0, 1, 1);
    cyc(1, 1, 8'hAD, 0, 1, 1);
    cyc(1, 0, 0, 1, 1, 1);
    cyc(1, 0, 0, 0, 1, 1);
    chk("flush_word", od_m, 32'hDEAD0000);
    chk("flush_cnt", oc_m, 2);
    for (int i = 0; i < 2; i++) cyc(1, 0, 0, 0, 1, 1);
    cyc(1, 0, 0, 1, 1, 1);
    cyc(1, 0, 0, 0, 1, 1);
    cyc(1, 0, 0, 0, 1, 1);
    cyc(1, 1, 8'h55, 0, 1, 1);
    cyc(1, 1, 8'h66, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) cyc(1, 1, 8'(i + 1), 0, 1, 1);
    chk("post_rst_word", od_m, 32'h01020304);
    for (int i = 0; i < 2; i++) cyc(1, 0, 0, 0, 1, 1);
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 99) != 0, 1'($urandom), 8'($urandom), $urandom_range(0, 9) == 0, 1'($urandom), 1);
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 0, 1, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
